// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file write sequencer.
package regfile_pkg;

   localparam int unsigned WIDTH_DEF = 32;
   localparam int unsigned NREGS_DEF = 32;

   // Register address width for a given register count (at least one bit).
   function automatic int unsigned addr_w(input int unsigned nregs);
      return (nregs <= 1) ? 1 : $clog2(nregs);
   endfunction

   localparam int unsigned ADDR_W_DEF = addr_w(NREGS_DEF);

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [WIDTH_DEF-1:0]  data;
   } entry_t;

endpackage

// File: rtl/regfile_write_sequencer_if.sv
// Writeback request, register file write port and forwarding lookup bundle.
interface regfile_write_sequencer_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CNT_W  = 3
) ();

   logic              wb_valid;
   logic              wb_ready;
   logic [ADDR_W-1:0] wb_addr;
   logic [WIDTH-1:0]  wb_data;
   logic              hold;
   logic              rf_write;
   logic [ADDR_W-1:0] rf_addr;
   logic [WIDTH-1:0]  rf_data;
   logic [ADDR_W-1:0] lk_addr1;
   logic [ADDR_W-1:0] lk_addr2;
   logic              lk_hit1;
   logic              lk_hit2;
   logic [WIDTH-1:0]  lk_data1;
   logic [WIDTH-1:0]  lk_data2;
   logic [CNT_W-1:0]  pending;

   modport master (
      output wb_valid, wb_addr, wb_data, hold, lk_addr1, lk_addr2,
      input  wb_ready, rf_write, rf_addr, rf_data,
             lk_hit1, lk_hit2, lk_data1, lk_data2, pending
   );

   modport slave (
      input  wb_valid, wb_addr, wb_data, hold, lk_addr1, lk_addr2,
      output wb_ready, rf_write, rf_addr, rf_data,
             lk_hit1, lk_hit2, lk_data1, lk_data2, pending
   );

endinterface

// File: rtl/wb_lookup_cam.sv
// Newest-first priority match of one lookup address over the queued entries.
module wb_lookup_cam #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic [ADDR_W-1:0] ent_addr [DEPTH],
   input  logic [WIDTH-1:0]  ent_data [DEPTH],
   input  logic [PTR_W-1:0]  head,
   input  logic [CNT_W-1:0]  count,
   input  logic [ADDR_W-1:0] lk_addr,
   output logic              hit,
   output logic [WIDTH-1:0]  data
);

   logic [PTR_W-1:0] idx;

   // Walk oldest to newest so the last match (the newest) wins.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if ((CNT_W'(i) < count) && (ent_addr[idx] == lk_addr)) begin
            hit  = 1'b1;
            data = ent_data[idx];
         end
      end
   end

endmodule

// File: rtl/regfile_write_sequencer.sv
// In-order writeback queue driving the register file write port, with
// two forwarding lookup ports over the not-yet-committed entries.
module regfile_write_sequencer
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH   = WIDTH_DEF,
   parameter int unsigned NREGS   = NREGS_DEF,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned DROP_R0 = 1
) (
   input logic clk,
   input logic rst,
   regfile_write_sequencer_if.slave bus
);

   localparam int unsigned ADDR_W = addr_w(NREGS);
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;

   logic [ADDR_W-1:0] q_addr [DEPTH];
   logic [WIDTH-1:0]  q_data [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;

   logic              drop_c;
   logic              push_c;
   logic              pop_c;
   logic [CNT_W-1:0]  lk_count_c;
   logic              hit1_c;
   logic              hit2_c;
   logic [WIDTH-1:0]  data1_c;
   logic [WIDTH-1:0]  data2_c;

   assign drop_c = (DROP_R0 != 0) && (bus.wb_addr == '0);
   assign push_c = bus.wb_valid && bus.wb_ready && !drop_c;
   assign pop_c  = bus.rf_write;

   // Ready is gated by reset so nothing handshakes while the queue is cleared.
   assign bus.wb_ready = !rst && (count != CNT_W'(DEPTH));
   assign bus.rf_write = !rst && !bus.hold && (count != '0);
   assign bus.rf_addr  = bus.rf_write ? q_addr[head] : '0;
   assign bus.rf_data  = bus.rf_write ? q_data[head] : '0;
   assign bus.pending  = count;

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push_c) tail <= tail + PTR_W'(1);
         if (pop_c)  head <= head + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry payloads need no reset; validity is defined by head and count.
   always_ff @(posedge clk) begin
      if (push_c) begin
         q_addr[tail] <= bus.wb_addr;
         q_data[tail] <= bus.wb_data;
      end
   end

   assign lk_count_c = rst ? '0 : count;

   wb_lookup_cam #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_cam1 (
      .ent_addr (q_addr),
      .ent_data (q_data),
      .head     (head),
      .count    (lk_count_c),
      .lk_addr  (bus.lk_addr1),
      .hit      (hit1_c),
      .data     (data1_c)
   );

   wb_lookup_cam #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_cam2 (
      .ent_addr (q_addr),
      .ent_data (q_data),
      .head     (head),
      .count    (lk_count_c),
      .lk_addr  (bus.lk_addr2),
      .hit      (hit2_c),
      .data     (data2_c)
   );

   // Register 0 is never forwarded when its writes are discarded.
   always_comb begin
      bus.lk_hit1  = hit1_c;
      bus.lk_data1 = data1_c;
      bus.lk_hit2  = hit2_c;
      bus.lk_data2 = data2_c;
      if ((DROP_R0 != 0) && (bus.lk_addr1 == '0)) begin
         bus.lk_hit1  = 1'b0;
         bus.lk_data1 = '0;
      end
      if ((DROP_R0 != 0) && (bus.lk_addr2 == '0)) begin
         bus.lk_hit2  = 1'b0;
         bus.lk_data2 = '0;
      end
   end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed self-checking bench for regfile_write_sequencer.
module tb_regfile_write_sequencer;
   import regfile_pkg::*;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   regfile_write_sequencer_if #(.WIDTH(32), .ADDR_W(5), .CNT_W(3)) bus ();

   regfile_write_sequencer #(.WIDTH(32), .NREGS(32), .DEPTH(4), .DROP_R0(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
      bus.wb_valid = v;
      bus.wb_addr  = a;
      bus.wb_data  = d;
   endtask

   entry_t fill_q [4];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      drive(1'b0, 5'd0, 32'd0);
      bus.hold     = 1'b0;
      bus.lk_addr1 = 5'd0;
      bus.lk_addr2 = 5'd0;
      #1;
      check("ready_in_reset", 32'(bus.wb_ready), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_pending",  32'(bus.pending),  32'd0);
      check("rst_rf_write", 32'(bus.rf_write), 32'd0);
      check("rst_rf_addr",  32'(bus.rf_addr),  32'd0);
      check("rst_rf_data",  bus.rf_data,       32'd0);
      check("rst_hit1",     32'(bus.lk_hit1),  32'd0);
      check("rst_data1",    bus.lk_data1,      32'd0);
      check("rst_ready",    32'(bus.wb_ready), 32'd1);

      // Single write with one-cycle latency.
      drive(1'b1, 5'd10, 32'd255);
      tick();
      drive(1'b0, 5'd0, 32'd0);
      bus.lk_addr1 = 5'd10;
      #1;
      check("single_pending", 32'(bus.pending),  32'd1);
      check("single_write",   32'(bus.rf_write), 32'd1);
      check("single_addr",    32'(bus.rf_addr),  32'd10);
      check("single_data",    bus.rf_data,       32'd255);
      check("single_fwd_hit", 32'(bus.lk_hit1),  32'd1);
      check("single_fwd_dat", bus.lk_data1,      32'd255);
      tick();
      check("single_drained", 32'(bus.pending),  32'd0);
      check("single_idle",    32'(bus.rf_write), 32'd0);

      // Fill under hold, then drain in order.
      fill_q[0] = '{addr: 5'd1, data: 32'h11};
      fill_q[1] = '{addr: 5'd2, data: 32'h22};
      fill_q[2] = '{addr: 5'd3, data: 32'h33};
      fill_q[3] = '{addr: 5'd4, data: 32'h44};
      bus.hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, fill_q[i].addr, fill_q[i].data);
         tick();
      end
      drive(1'b1, 5'd5, 32'h55);
      #1;
      check("full_pending", 32'(bus.pending),  32'd4);
      check("full_ready",   32'(bus.wb_ready), 32'd0);
      check("full_hold",    32'(bus.rf_write), 32'd0);
      tick();
      check("full_no_push", 32'(bus.pending),  32'd4);
      drive(1'b0, 5'd0, 32'd0);
      bus.hold = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("drain_write", 32'(bus.rf_write), 32'd1);
         check("drain_addr",  32'(bus.rf_addr),  32'(fill_q[i].addr));
         check("drain_data",  bus.rf_data,       fill_q[i].data);
         check("drain_pend",  32'(bus.pending),  32'(4 - i));
         tick();
         check("drain_ready", 32'(bus.wb_ready), 32'd1);
      end
      check("drain_empty", 32'(bus.pending),  32'd0);
      check("drain_idle",  32'(bus.rf_write), 32'd0);

      // Forwarding returns the newest of two writes to one register.
      bus.hold = 1'b1;
      drive(1'b1, 5'd5, 32'hA);
      tick();
      drive(1'b1, 5'd5, 32'hB);
      tick();
      drive(1'b0, 5'd0, 32'd0);
      bus.lk_addr1 = 5'd5;
      bus.lk_addr2 = 5'd6;
      #1;
      check("fwd_hit1",  32'(bus.lk_hit1), 32'd1);
      check("fwd_data1", bus.lk_data1,     32'hB);
      check("fwd_hit2",  32'(bus.lk_hit2), 32'd0);
      check("fwd_data2", bus.lk_data2,     32'd0);
      bus.hold = 1'b0;
      #1;
      check("fwd_pop_a",  bus.rf_data,     32'hA);
      check("fwd_pop_hit", bus.lk_data1,   32'hB);
      tick();
      check("fwd_pop_b",  bus.rf_data,     32'hB);
      check("fwd_last",   bus.lk_data1,    32'hB);
      tick();
      check("fwd_gone",   32'(bus.lk_hit1), 32'd0);

      // Register 0 writes complete the handshake but are discarded.
      drive(1'b1, 5'd0, 32'hDEAD);
      bus.lk_addr1 = 5'd0;
      #1;
      check("r0_ready", 32'(bus.wb_ready), 32'd1);
      check("r0_hit",   32'(bus.lk_hit1),  32'd0);
      tick();
      drive(1'b0, 5'd0, 32'd0);
      #1;
      check("r0_pending", 32'(bus.pending),  32'd0);
      check("r0_write",   32'(bus.rf_write), 32'd0);
      check("r0_hit_aft", 32'(bus.lk_hit1),  32'd0);
      tick();
      check("r0_write2",  32'(bus.rf_write), 32'd0);

      // Back-to-back stream across pointer wrap.
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 5'(11 + k), 32'(256 + k));
         bus.lk_addr1 = 5'(11 + k);
         bus.lk_addr2 = 5'(10 + k);
         #1;
         check("stream_ready",  32'(bus.wb_ready), 32'd1);
         check("stream_write",  32'(bus.rf_write), 32'(k > 0));
         check("stream_le1",    32'(bus.pending <= 3'd1), 32'd1);
         check("stream_nohit",  32'(bus.lk_hit1), 32'd0);
         check("stream_pophit", 32'(bus.lk_hit2), 32'(k > 0));
         if (k > 0) begin
            check("stream_addr", 32'(bus.rf_addr), 32'(10 + k));
            check("stream_data", bus.rf_data,      32'(255 + k));
            check("stream_fwd",  bus.lk_data2,     32'(255 + k));
         end
         tick();
      end
      drive(1'b0, 5'd0, 32'd0);
      #1;
      check("stream_last_addr", 32'(bus.rf_addr), 32'd20);
      check("stream_last_data", bus.rf_data,      32'd265);
      tick();
      check("stream_empty", 32'(bus.pending), 32'd0);

      // Reset discards queued entries.
      bus.hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'(7 + i), 32'(32'h700 + i));
         tick();
      end
      drive(1'b0, 5'd0, 32'd0);
      bus.lk_addr1 = 5'd7;
      check("mid_pending", 32'(bus.pending), 32'd3);
      rst = 1'b1;
      bus.hold = 1'b0;
      #1;
      check("mid_rst_write", 32'(bus.rf_write), 32'd0);
      check("mid_rst_ready", 32'(bus.wb_ready), 32'd0);
      check("mid_rst_hit",   32'(bus.lk_hit1),  32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_pending", 32'(bus.pending),  32'd0);
      check("post_rst_write",   32'(bus.rf_write), 32'd0);
      check("post_rst_hit",     32'(bus.lk_hit1),  32'd0);
      drive(1'b1, 5'd12, 32'h1234);
      tick();
      drive(1'b0, 5'd0, 32'd0);
      #1;
      check("post_rst_wr",   32'(bus.rf_write), 32'd1);
      check("post_rst_addr", 32'(bus.rf_addr),  32'd12);
      check("post_rst_data", bus.rf_data,       32'h1234);
      tick();
      check("post_rst_done", 32'(bus.pending),  32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
